// File: rtl/writeback_stage_pkg.sv
// Shared CPU pipeline definitions: widths and the field layout of the
// memory-to-writeback bus, so packing and unpacking stay consistent.
package writeback_stage_pkg;

  localparam int XLEN            = 64;
  localparam int REG_IDX_W       = 5;
  localparam int MS_TO_WS_BUS_WD = 1 + REG_IDX_W + 2 * XLEN;  // 134
  localparam int WS_TO_RF_BUS_WD = 1 + REG_IDX_W + XLEN;      // 70

  // Field positions inside ms_to_ws_bus: {gr_we, dest, final_result, pc}
  localparam int PC_LSB     = 0;
  localparam int PC_MSB     = PC_LSB + XLEN - 1;              // 63
  localparam int RESULT_LSB = PC_MSB + 1;                     // 64
  localparam int RESULT_MSB = RESULT_LSB + XLEN - 1;          // 127
  localparam int DEST_LSB   = RESULT_MSB + 1;                 // 128
  localparam int DEST_MSB   = DEST_LSB + REG_IDX_W - 1;       // 132
  localparam int GR_WE_BIT  = DEST_MSB + 1;                   // 133

endpackage

// File: rtl/writeback_stage_pipe_reg.sv
// Generic valid+payload pipeline register. The valid bit follows the
// upstream valid whenever the stage accepts; the payload only loads on an
// accepted valid transfer, so bubbles leave the last payload in place.
module writeback_stage_pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;

  // Valid/payload state with asynchronous clear and load-enabled capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      data_r  <= {WIDTH{1'b0}};
    end else if (load_en) begin
      valid_r <= in_valid;
      if (in_valid) begin
        data_r <= in_data;
      end else begin
        data_r <= data_r;
      end
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;

endmodule

// File: rtl/writeback_stage.sv
// Write-back stage: registers one instruction from the memory stage and
// turns it into a register-file write request plus debug trace outputs.
module writeback_stage
  import writeback_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ws_allowin,
  input  logic                       ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
  output logic [XLEN-1:0]            debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [REG_IDX_W-1:0]       debug_wb_rf_wnum,
  output logic [XLEN-1:0]            debug_wb_rf_wdata
);

  logic                       ws_ready_go_s;
  logic                       ws_valid_r;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus_r;

  logic                       gr_we_s;
  logic [REG_IDX_W-1:0]       dest_s;
  logic [XLEN-1:0]            final_result_s;
  logic [XLEN-1:0]            pc_s;
  logic                       rf_we_s;

  // Write-back has no multi-cycle work, so it never holds an instruction.
  assign ws_ready_go_s = 1'b1;
  assign ws_allowin    = !ws_valid_r || ws_ready_go_s;

  writeback_stage_pipe_reg #(
    .WIDTH (MS_TO_WS_BUS_WD)
  ) u_pipe_reg (
    .clk       (clk),
    .reset     (reset),
    .load_en   (ws_allowin),
    .in_valid  (ms_to_ws_valid),
    .in_data   (ms_to_ws_bus),
    .out_valid (ws_valid_r),
    .out_data  (ms_to_ws_bus_r)
  );

  // Unpack the registered bus
  assign gr_we_s        = ms_to_ws_bus_r[GR_WE_BIT];
  assign dest_s         = ms_to_ws_bus_r[DEST_MSB:DEST_LSB];
  assign final_result_s = ms_to_ws_bus_r[RESULT_MSB:RESULT_LSB];
  assign pc_s           = ms_to_ws_bus_r[PC_MSB:PC_LSB];

  // A stale payload left behind by a bubble must never write; x0 writes are
  // passed on and discarded by the register file itself.
  assign rf_we_s      = gr_we_s && ws_valid_r;
  assign ws_to_rf_bus = {rf_we_s, dest_s, final_result_s};

  assign debug_wb_pc       = pc_s;
  assign debug_wb_rf_wen   = {4{rf_we_s}};
  assign debug_wb_rf_wnum  = dest_s;
  assign debug_wb_rf_wdata = final_result_s;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
module tb_writeback_stage;

  logic         clk;
  logic         reset;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [133:0] ms_to_ws_bus;
  logic [69:0]  ws_to_rf_bus;
  logic [63:0]  debug_wb_pc;
  logic [3:0]   debug_wb_rf_wen;
  logic [4:0]   debug_wb_rf_wnum;
  logic [63:0]  debug_wb_rf_wdata;

  int tests_run;
  int tests_failed;

  writeback_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ws_to_rf_bus      (ws_to_rf_bus),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check every output against hand-written expected field values
  task automatic chk_all(input string tag, input logic we, input logic [4:0] wnum,
                         input logic [63:0] wdata, input logic [63:0] pc);
    chk({tag, ".rf_bus"}, 134'(ws_to_rf_bus), 134'({we, wnum, wdata}));
    chk({tag, ".pc"},     134'(debug_wb_pc), 134'(pc));
    chk({tag, ".wen"},    134'(debug_wb_rf_wen), 134'({4{we}}));
    chk({tag, ".wnum"},   134'(debug_wb_rf_wnum), 134'(wnum));
    chk({tag, ".wdata"},  134'(debug_wb_rf_wdata), 134'(wdata));
    chk({tag, ".allowin"}, 134'(ws_allowin), 134'(1'b1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    reset          = 1'b1;
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = {1'b1, 5'd2, 64'd20, 64'd1};

    // Reset hold: valid input present, nothing captured
    #2;
    chk_all("reset_hold", 1'b0, 5'd0, 64'd0, 64'd0);
    #5;  // past the edge at t=5
    chk_all("reset_no_capture", 1'b0, 5'd0, 64'd0, 64'd0);
    #3;  // t=10
    reset = 1'b0;

    // First edge after release captures
    tick();
    chk_all("capture", 1'b1, 5'd2, 64'd20, 64'd1);

    // gr_we=0 instruction: no write enable, fields still visible
    ms_to_ws_bus = {1'b0, 5'd7, 64'hABCD, 64'h100};
    tick();
    chk_all("no_we", 1'b0, 5'd7, 64'hABCD, 64'h100);

    // Valid write followed by a bubble
    ms_to_ws_bus = {1'b1, 5'd3, 64'h33, 64'h200};
    tick();
    chk_all("pre_bubble", 1'b1, 5'd3, 64'h33, 64'h200);
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus   = {1'b1, 5'd31, 64'hDEAD, 64'hBEEF};
    tick();
    chk_all("bubble", 1'b0, 5'd3, 64'h33, 64'h200);

    // Back-to-back stream
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = {1'b1, 5'd10, 64'h1010, 64'h10};
    tick();
    chk_all("b2b_0", 1'b1, 5'd10, 64'h1010, 64'h10);
    ms_to_ws_bus = {1'b1, 5'd11, 64'h1414, 64'h14};
    #3;  // input changed, no edge yet: outputs must not follow the input
    chk_all("b2b_no_comb", 1'b1, 5'd10, 64'h1010, 64'h10);
    tick();
    chk_all("b2b_1", 1'b1, 5'd11, 64'h1414, 64'h14);
    ms_to_ws_bus = {1'b1, 5'd0, 64'h1818, 64'h18};
    tick();
    chk_all("b2b_2_x0", 1'b1, 5'd0, 64'h1818, 64'h18);

    // Asynchronous reset between edges (t=76 -> 78)
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 1'b0, 5'd0, 64'd0, 64'd0);
    #1;  // t=80
    reset        = 1'b0;
    ms_to_ws_bus = {1'b1, 5'd9, 64'd99, 64'h300};
    tick();
    chk_all("after_reset", 1'b1, 5'd9, 64'd99, 64'h300);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
